// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC: one shift-add micro-rotation stage reused ITER times per operand set.
// Optional gain compensation state enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_iter_engine #(
  parameter int SYM_WIDTH = 1,
  parameter int INT_WIDTH = 1,
  parameter int DEC_WIDTH = 14,
  parameter int ITER      = 14,
  localparam int W        = SYM_WIDTH + INT_WIDTH + DEC_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  input  logic signed [W-1:0] z_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] x_out,
  output logic signed [W-1:0] y_out,
  output logic signed [W-1:0] z_out,
  output logic                busy
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  if (ITER < 1 || ITER > W - 1) begin : g_iter_range
    $error("cordic_iter_engine: ITER must lie in 1..W-1");
  end

  // Elaboration-time atan(2^-i) in the fixed-point format; series converges for i >= 1.
  function automatic int atan_fixed(input int i);
    real t, term, acc, scale;
    if (i == 0) begin
      acc = 0.78539816339744831;
    end else begin
      t = 1.0;
      for (int k = 0; k < i; k++) t = t / 2.0;
      acc  = 0.0;
      term = t;
      for (int n = 0; n < 30; n++) begin
        acc  = acc + (((n % 2) == 0) ? term : -term) / real'(2 * n + 1);
        term = term * t * t;
      end
    end
    scale = 1.0;
    for (int k = 0; k < DEC_WIDTH; k++) scale = scale * 2.0;
    return $rtoi(acc * scale + 0.5);
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  localparam int K_INT = $rtoi(0.6072529350 * (2.0 ** DEC_WIDTH) + 0.5);
  localparam logic signed [2*W-1:0] K_2W = (2*W)'(K_INT);

  function automatic logic signed [W-1:0] gain_scale(input logic signed [W-1:0] v);
    logic signed [2*W-1:0] p;
    p = $signed({{W{v[W-1]}}, v}) * K_2W;
    return W'(p >>> DEC_WIDTH);
  endfunction
`endif

  logic signed [W-1:0] atan_tab [ITER];
  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam int A = atan_fixed(g);
    assign atan_tab[g] = W'(A);
  end

  typedef enum logic [1:0] {IDLE, RUN, COMP, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic                mode_r;
  logic signed [W-1:0] xr, yr, zr;
  logic signed [W-1:0] xn, yn, zn;
  logic signed [W-1:0] xs, ys, atan_i;
  logic                neg;

  always_comb begin
    neg    = mode_r ? ~yr[W-1] : zr[W-1];
    xs     = xr >>> cnt;
    ys     = yr >>> cnt;
    atan_i = atan_tab[cnt];
    if (neg) begin
      xn = xr + ys;
      yn = yr - xs;
      zn = zr + atan_i;
    end else begin
      xn = xr - ys;
      yn = yr + xs;
      zn = zr - atan_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_r    <= 1'b0;
      xr        <= '0;
      yr        <= '0;
      zr        <= '0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr       <= x_in;
            yr       <= y_in;
            zr       <= z_in;
            mode_r   <= in_mode;
            cnt      <= '0;
            state    <= RUN;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        // ---- micro-rotation stage, reused once per cycle ----
        RUN: begin
          xr  <= xn;
          yr  <= yn;
          zr  <= zn;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= COMP;
`else
            state     <= DONE;
            out_valid <= 1'b1;
            x_out     <= xn;
            y_out     <= yn;
            z_out     <= zn;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        // ---- gain compensation stage ----
        COMP: begin
          state     <= DONE;
          out_valid <= 1'b1;
          x_out     <= gain_scale(xr);
          y_out     <= gain_scale(yr);
          z_out     <= zr;
        end
`endif
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed, table-driven bench for cordic_iter_engine (W=16, DEC_WIDTH=14, ITER=14).
module tb_cordic_iter_engine;

  localparam int W    = 16;
  localparam int ITER = 14;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITER + 1;
`else
  localparam int LAT = ITER;
`endif
  localparam int SPACE = LAT + 2;

  typedef struct {
    logic mode;
    int   x, y, z;
    int   ex, ey, ez;
    int   tx, ty, tz;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_mode = 1'b0;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] x_in = '0, y_in = '0, z_in = '0;
  logic                in_ready, out_valid, busy;
  logic signed [W-1:0] x_out, y_out, z_out;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int acc_cyc = 0;
  vec_t vecs [3];

  cordic_iter_engine dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .x_in     (x_in),
    .y_in     (y_in),
    .z_in     (z_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out    (x_out),
    .y_out    (y_out),
    .z_out    (z_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp, input int tol);
    n_chk++;
    if (act >= exp - tol && act <= exp + tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
  endtask

  task automatic start_op(input vec_t v);
    @(negedge clk);
    x_in     = W'(v.x);
    y_in     = W'(v.y);
    z_in     = W'(v.z);
    in_mode  = v.mode;
    in_valid = 1'b1;
    chk("accept_in_ready", int'(in_ready), 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic wait_valid(output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_timeout", int'(out_valid), 1, 0);
    lat = cyc - acc_cyc;
  endtask

  task automatic check_result(input string tag, input vec_t v);
    chk({tag, "_x"}, int'(x_out), v.ex, v.tx);
    chk({tag, "_y"}, int'(y_out), v.ey, v.ty);
    chk({tag, "_z"}, int'(z_out), v.ez, v.tz);
  endtask

  initial begin
    int lat;
    int hi;
    int sx, sy, sz;
    int nres;
    int rt [3];
    int rx [3], ry [3], rz [3];
    int nxt;
    logic prev_v, prev_b;

`ifdef CORDIC_GAIN_COMP_EN
    vecs[0] = '{1'b0, 16384, 0, 8579, 14189, 8192, 0, 4, 4, 4};
`else
    vecs[0] = '{1'b0, 9949, 0, 8579, 14189, 8192, 0, 4, 4, 4};
`endif
`ifdef CORDIC_GAIN_COMP_EN
    vecs[1] = '{1'b1, 8192, 8192, 0, 11585, 0, 12868, 8, 4, 4};
    vecs[2] = '{1'b1, 8192, 0, 0, 8192, 0, 0, 8, 4, 4};
`else
    vecs[1] = '{1'b1, 8192, 8192, 0, 19079, 0, 12868, 8, 4, 4};
    vecs[2] = '{1'b1, 8192, 0, 0, 13490, 0, 0, 8, 4, 4};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_busy", int'(busy), 0, 0);
    chk("rst_in_ready", int'(in_ready), 1, 0);
    chk("rst_x_out", int'(x_out), 0, 0);
    chk("rst_y_out", int'(y_out), 0, 0);
    chk("rst_z_out", int'(z_out), 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single operations
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_op(vecs[k]);
      chk("run_busy", int'(busy), 1, 0);
      chk("run_in_ready", int'(in_ready), 0, 0);
      chk("run_no_valid", int'(out_valid), 0, 0);
      wait_valid(lat);
      chk("latency", lat, LAT, 0);
      check_result($sformatf("vec%0d", k), vecs[k]);
      chk("done_in_ready", int'(in_ready), 0, 0);
      @(negedge clk);
      chk("idle_in_ready", int'(in_ready), 1, 0);
      chk("idle_out_valid", int'(out_valid), 0, 0);
    end

    // Backpressure in DONE
    out_ready = 1'b0;
    start_op(vecs[0]);
    wait_valid(lat);
    sx = int'(x_out); sy = int'(y_out); sz = int'(z_out);
    chk("bp_x", sx, vecs[0].ex, vecs[0].tx);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = (k % 2 == 0);
      x_in     = W'(1000 * k);
      chk("bp_out_valid", int'(out_valid), 1, 0);
      chk("bp_in_ready", int'(in_ready), 0, 0);
      chk("bp_x_hold", int'(x_out), sx, 0);
      chk("bp_y_hold", int'(y_out), sy, 0);
      chk("bp_z_hold", int'(z_out), sz, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", int'(in_ready), 1, 0);
    chk("bp_release_out_valid", int'(out_valid), 0, 0);
    chk("bp_release_busy", int'(busy), 0, 0);
    chk("bp_release_x_kept", int'(x_out), sx, 0);
    @(negedge clk);
    chk("bp_no_accept", int'(busy), 0, 0);

    // Reset in the middle of RUN
    start_op(vecs[1]);
    repeat (6) @(negedge clk);
    chk("mid_run_busy", int'(busy), 1, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0, 0);
    chk("abort_busy", int'(busy), 0, 0);
    chk("abort_in_ready", int'(in_ready), 1, 0);
    chk("abort_x_out", int'(x_out), 0, 0);
    chk("abort_y_out", int'(y_out), 0, 0);
    chk("abort_z_out", int'(z_out), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid || busy) hi++;
    end
    chk("abort_no_stale", hi, 0, 0);
    start_op(vecs[0]);
    wait_valid(lat);
    chk("post_abort_latency", lat, LAT, 0);
    check_result("post_abort", vecs[0]);
    @(negedge clk);

    // Back-to-back with in_valid and out_ready held high
    @(negedge clk);
    x_in = W'(vecs[0].x); y_in = W'(vecs[0].y); z_in = W'(vecs[0].z);
    in_mode  = vecs[0].mode;
    in_valid = 1'b1;
    nxt = 1;
    nres = 0;
    prev_v = 1'b0;
    prev_b = busy;
    for (int n = 0; n < 200 && nres < 3; n++) begin
      @(negedge clk);
      if (busy && !prev_b && nxt < 3) begin
        x_in = W'(vecs[nxt].x); y_in = W'(vecs[nxt].y); z_in = W'(vecs[nxt].z);
        in_mode = vecs[nxt].mode;
        nxt++;
      end
      if (out_valid && !prev_v) begin
        rt[nres] = cyc;
        rx[nres] = int'(x_out); ry[nres] = int'(y_out); rz[nres] = int'(z_out);
        nres++;
      end
      prev_v = out_valid;
      prev_b = busy;
    end
    in_valid = 1'b0;
    chk("b2b_count", nres, 3, 0);
    if (nres == 3) begin
      chk("b2b_space_01", rt[1] - rt[0], SPACE, 0);
      chk("b2b_space_12", rt[2] - rt[1], SPACE, 0);
      for (int k = 0; k < 3; k++) begin
        chk("b2b_x", rx[k], vecs[k].ex, vecs[k].tx);
        chk("b2b_y", ry[k], vecs[k].ey, vecs[k].ty);
        chk("b2b_z", rz[k], vecs[k].ez, vecs[k].tz);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cordic_iter_engine.md
Name: cordic_iter_engine

Overview:
- Iterative, area-reduced CORDIC. One shift-add micro-rotation datapath is reused for ITER cycles per operand set.
- Successor to the unrolled per-stage iteration cell. Adds runtime rotation/vectoring mode select, a valid/ready handshake on both sides, an internal arctangent table and optional gain compensation.
- Sits between the trig front-end (angle pre-processing) and its consumers (sin/cos, atan2, magnitude).

Parameters:
- SYM_WIDTH, 1, sign bits of the fixed-point format.
- INT_WIDTH, 1, integer bits.
- DEC_WIDTH, 14, fraction bits. Word width W = SYM_WIDTH+INT_WIDTH+DEC_WIDTH.
- ITER, 14, micro-rotations per operation. Legal range 1..W-1; an out-of-range value is an elaboration error.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input operand set is valid.
- in_ready, out, 1, engine can accept; equals (state==IDLE).
- in_mode, in, 1, 0 = rotation (drive z to 0), 1 = vectoring (drive y to 0).
- x_in / y_in / z_in, in, W each, signed operands; z in radians, same fixed-point format.
- out_valid, out, 1, result valid.
- out_ready, in, 1, consumer accepts the result.
- x_out / y_out / z_out, out, W each, signed results.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE; iteration counter, x/y/z registers and the mode register clear to 0.
  - out_valid=0, busy=0, x_out/y_out/z_out=0, in_ready=1.
  - Reset during RUN or DONE aborts the operation; no output handshake occurs.
- FSM states IDLE, RUN, [COMP], DONE:
  - IDLE: in_valid&in_ready at an edge latches x_in/y_in/z_in/in_mode, sets i=0 and goes to RUN. in_valid low means stay in IDLE.
  - RUN: each edge performs micro-rotation i and increments i. After the edge where i=ITER-1 it goes to COMP if the macro is defined, otherwise to DONE.
  - COMP: one cycle of gain scaling, then DONE.
  - DONE: out_valid=1 and outputs are stable. out_ready high at an edge means the result is taken and the FSM goes to IDLE. out_ready low means hold all values indefinitely.
  - in_valid is ignored outside IDLE; there is no same-cycle DONE-to-accept. Peak throughput is one operation per ITER+2 cycles (ITER+3 with COMP).
- Latency: out_valid rises exactly ITER cycles after the accepting edge (ITER+1 with COMP).
- Direction flag neg:
  - rotation: neg = z[W-1].
  - vectoring: neg = ~y[W-1] (y >= 0).
- Micro-rotation i:
  - neg=1: x' = x + (y>>>i); y' = y - (x>>>i); z' = z + atan_i.
  - neg=0: x' = x - (y>>>i); y' = y + (x>>>i); z' = z - atan_i.
  - All terms use pre-update x/y/z.
- Arithmetic:
  - Shifts are arithmetic; the counter width is clog2(ITER).
  - All adds are W-bit two's complement and wrap on overflow, with no saturation. Callers keep |x|,|y| ≤ 2^(W-2)/1.647 to stay in range.
- atan_i = round(atan(2^-i)·2^DEC_WIDTH), built as an elaboration-time constant table of ITER entries; no runtime load.
- Output registers load only on entry to DONE; x_out/y_out/z_out are otherwise unchanged.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined:
  - Adds the COMP state; x and y are multiplied by K = round(0.6072529350·2^DEC_WIDTH).
  - Each product is 2W bits, arithmetic-shifted right by DEC_WIDTH and truncated to W bits. z is unchanged.
  - Latency becomes ITER+1.
- Not defined:
  - No multiplier and no COMP state; outputs carry the CORDIC gain (≈1.6468). Callers pre-scale x_in by K.

Test Plan (defaults W=16, DEC_WIDTH=14, 1.0=16384, macro off unless stated):
- Rotation: x_in=9949, y_in=0, z_in=8579 (π/6), mode 0 -> out_valid exactly 14 cycles after accept; x_out=14189±4, y_out=8192±4, z_out=0±4.
- Vectoring: x_in=8192, y_in=8192, z_in=0, mode 1 -> z_out=12868±4 (π/4), y_out=0±4, x_out=19079±8.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs and out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge, in_ready=1.
- Reset mid-RUN: deassert rst_n at i=6 -> outputs/out_valid=0 immediately; after release a fresh operation produces the correct result with no stale output.
- Back-to-back: in_valid held high, out_ready held high with 3 distinct operand sets -> 3 results in order, spaced 16 cycles apart.
- Macro CORDIC_GAIN_COMP_EN: x_in=16384, y_in=0, z_in=8579 -> latency 15; x_out=14189±4, y_out=8192±4.
